// File: rtl/eaglesong_coeff_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : eaglesong_coeff_sequencer
// Description : Accepts a state-word index on a valid/ready request port and
//               streams that word's Eaglesong theta rotation coefficients,
//               one per beat, on a valid/ready output port tagged with the
//               beat number, a last flag and an out-of-range error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module eaglesong_coeff_sequencer #(
    parameter int COEFF_WIDTH     = 5,
    parameter int NUM_WORDS       = 16,
    parameter int COEFFS_PER_WORD = 3,
    parameter int IDX_WIDTH       = 7,
    parameter logic [NUM_WORDS*COEFFS_PER_WORD*COEFF_WIDTH-1:0] COEFF_TABLE = {
        5'd13, 5'd1,  5'd0,   5'd8,  5'd7,  5'd0,   5'd17, 5'd7,  5'd0,
        5'd27, 5'd12, 5'd0,   5'd31, 5'd4,  5'd0,   5'd7,  5'd4,  5'd0,
        5'd18, 5'd12, 5'd0,   5'd22, 5'd18, 5'd0,   5'd12, 5'd3,  5'd0,
        5'd26, 5'd17, 5'd0,   5'd8,  5'd3,  5'd0,   5'd31, 5'd27, 5'd0,
        5'd14, 5'd3,  5'd0,   5'd19, 5'd4,  5'd0,   5'd22, 5'd13, 5'd0,
        5'd4,  5'd2,  5'd0
    },
    localparam int BEAT_W = (COEFFS_PER_WORD > 1) ? $clog2(COEFFS_PER_WORD) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [IDX_WIDTH-1:0]   req_word_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [COEFF_WIDTH-1:0] out_coeff_o,
    output logic [BEAT_W-1:0]      out_beat_o,
    output logic                   out_last_o,
    output logic                   out_err_o,
    output logic                   busy_o
);

    localparam int NUM_ENTRIES = NUM_WORDS * COEFFS_PER_WORD;
    localparam int ADDR_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    // One extra bit so NUM_WORDS is representable even when it equals 2**IDX_WIDTH.
    localparam logic [IDX_WIDTH:0] C_NUM_WORDS = (IDX_WIDTH+1)'(NUM_WORDS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [COEFF_WIDTH-1:0] coeff_q, coeff_d;
    logic                   last_q, last_d;
    logic                   err_q, err_d;

    logic [COEFF_WIDTH-1:0] w_tab [NUM_ENTRIES];
    logic                   w_req_bad;
    logic                   w_accept;
    logic [ADDR_W-1:0]      w_load_addr;
    logic [ADDR_W-1:0]      w_next_addr;
    logic [BEAT_W-1:0]      w_beat_nxt;

    // Unpack the flat coefficient vector into an addressable table.
    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_tab
        assign w_tab[e] = COEFF_TABLE[e*COEFF_WIDTH +: COEFF_WIDTH];
    end

    // Range check uses the full index width, so high bits can never alias
    // onto a legal word; the truncated address is only used when legal.
    assign w_req_bad   = ({1'b0, req_word_i} >= C_NUM_WORDS);
    assign w_load_addr = ADDR_W'(req_word_i) * ADDR_W'(COEFFS_PER_WORD);
    assign w_beat_nxt  = beat_q + BEAT_W'(1);
    assign w_next_addr = base_q + ADDR_W'(w_beat_nxt);

    // A new request may be taken while idle or on the final beat's transfer.
    assign req_ready_o = !rst && ((state_q == ST_IDLE) ||
                                  (last_q && out_ready_i));
    assign w_accept    = req_valid_i && req_ready_o;

    assign out_valid_o = (state_q == ST_STREAM);
    assign busy_o      = (state_q == ST_STREAM);
    assign out_coeff_o = coeff_q;
    assign out_beat_o  = beat_q;
    assign out_last_o  = last_q;
    assign out_err_o   = err_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        coeff_d = coeff_q;
        last_d  = last_q;
        err_d   = err_q;

        if (w_accept) begin
            // Load beat 0 of the new request (possibly chained onto a last beat).
            state_d = ST_STREAM;
            beat_d  = '0;
            if (w_req_bad) begin
                base_d  = '0;
                coeff_d = '0;
                last_d  = 1'b1;
                err_d   = 1'b1;
            end else begin
                base_d  = w_load_addr;
                coeff_d = w_tab[w_load_addr];
                last_d  = (COEFFS_PER_WORD == 1);
                err_d   = 1'b0;
            end
        end else if ((state_q == ST_STREAM) && out_ready_i) begin
            if (last_q) begin
                state_d = ST_IDLE;
                base_d  = '0;
                beat_d  = '0;
                coeff_d = '0;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end else begin
                beat_d  = w_beat_nxt;
                coeff_d = w_tab[w_next_addr];
                last_d  = (w_beat_nxt == BEAT_W'(COEFFS_PER_WORD - 1));
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            coeff_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            coeff_q <= coeff_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eaglesong_coeff_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eaglesong_coeff_sequencer
// Description : Self-checking bench for eaglesong_coeff_sequencer. A queue of
//               expected beats is filled from the coefficient table whenever
//               a request is accepted and drained on each output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eaglesong_coeff_sequencer;

    typedef struct packed {
        logic [4:0] coeff;
        logic [1:0] beat;
        logic       last;
        logic       err;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_word;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_coeff;
    logic [1:0] out_beat;
    logic       out_last;
    logic       out_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int tab [48] = '{0,2,4,   0,13,22, 0,4,19,  0,3,14,
                     0,27,31, 0,3,8,   0,17,26, 0,3,12,
                     0,18,22, 0,12,18, 0,4,7,   0,4,31,
                     0,12,27, 0,7,17,  0,7,8,   0,1,13};

    beat_t exp_q[$];
    bit    after_rst = 1'b0;

    eaglesong_coeff_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_word_i  (req_word),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_coeff_o (out_coeff),
        .out_beat_o  (out_beat),
        .out_last_o  (out_last),
        .out_err_o   (out_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cyc(input logic r, input logic rv, input logic [6:0] w, input logic ordy);
        logic  e_ready;
        logic  e_valid;
        beat_t h;
        rst       = r;
        req_valid = rv;
        req_word  = w;
        out_ready = ordy;
        #1;
        e_valid = (exp_q.size() != 0);
        e_ready = !r && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("busy", 32'(busy), 32'(e_valid));
        if (after_rst) begin
            chk("rst_coeff", 32'(out_coeff), 32'd0);
            chk("rst_beat", 32'(out_beat), 32'd0);
            chk("rst_last", 32'(out_last), 32'd0);
            chk("rst_err", 32'(out_err), 32'd0);
        end
        if (e_valid) begin
            h = exp_q[0];
            chk("out_coeff", 32'(out_coeff), 32'(h.coeff));
            chk("out_beat", 32'(out_beat), 32'(h.beat));
            chk("out_last", 32'(out_last), 32'(h.last));
            chk("out_err", 32'(out_err), 32'(h.err));
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (e_valid && ordy) void'(exp_q.pop_front());
            if (rv && e_ready) begin
                if (w >= 7'd16) begin
                    exp_q.push_back('{coeff: 5'd0, beat: 2'd0, last: 1'b1, err: 1'b1});
                end else begin
                    for (int b = 0; b < 3; b++)
                        exp_q.push_back('{coeff: 5'(tab[int'(w)*3 + b]), beat: 2'(b),
                                          last: (b == 2), err: 1'b0});
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_word  = 7'd3;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        after_rst = 1'b1;

        // Reset held two cycles with a pending request.
        cyc(1'b1, 1'b1, 7'd3, 1'b1);
        cyc(1'b1, 1'b1, 7'd3, 1'b1);

        // Word 4 with the sink always ready.
        cyc(1'b0, 1'b1, 7'd4, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 7'd0, 1'b1);

        // Word 15 with a stalling sink: 1,0,0,1,1.
        cyc(1'b0, 1'b1, 7'd15, 1'b1);
        cyc(1'b0, 1'b0, 7'd0, 1'b1);
        cyc(1'b0, 1'b0, 7'd0, 1'b0);
        cyc(1'b0, 1'b0, 7'd0, 1'b0);
        cyc(1'b0, 1'b0, 7'd0, 1'b1);
        cyc(1'b0, 1'b0, 7'd0, 1'b1);
        cyc(1'b0, 1'b0, 7'd0, 1'b1);

        // Back-to-back words 0 then 1 with request held.
        cyc(1'b0, 1'b1, 7'd0, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 7'd1, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 7'd0, 1'b1);

        // Out-of-range words, then a legal one.
        cyc(1'b0, 1'b1, 7'd16, 1'b1);
        cyc(1'b0, 1'b1, 7'd100, 1'b1);
        cyc(1'b0, 1'b1, 7'd2, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 7'd0, 1'b1);

        // Reset during beat 1 of word 5, then restream word 5.
        cyc(1'b0, 1'b1, 7'd5, 1'b1);
        cyc(1'b0, 1'b0, 7'd0, 1'b1);
        cyc(1'b1, 1'b0, 7'd0, 1'b1);
        cyc(1'b0, 1'b1, 7'd5, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 7'd0, 1'b1);

        // Randomised traffic, mostly legal indices, occasional reset.
        for (int i = 0; i < 600; i++) begin
            logic [6:0] w;
            w = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(16, 127))
                                            : 7'($urandom_range(0, 15));
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0), w,
                ($urandom_range(0, 3) != 0));
        end
        repeat (6) cyc(1'b0, 1'b0, 7'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
